// File: rtl/mem_cycle_sequencer.sv
// Memory-access machine-cycle sequencer: generates T0/T1(wait)/T2 progression and
// the bus/register-file strobes for read, write and opcode-fetch cycles.
module mem_cycle_sequencer #(
    parameter int N_SRC        = 4,
    parameter int SRC_W        = 2,
    parameter int WCFG_W       = 2,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [SRC_W-1:0]  SRC,
    input  logic [WCFG_W-1:0] WCFG,
    input  logic              TWAIT,
    output logic              BUSY,
    output logic [1:0]        XPT,
    output logic              MREQ,
    output logic              RD,
    output logic              WR,
    output logic              M1,
    output logic              ACT_AD,
    output logic [N_SRC-1:0]  AD_SEL,
    output logic              LATCH_DATA,
    output logic              INC_PC,
    output logic              DONE,
    output logic              ERR
);

    localparam int TO_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_T0, S_T1, S_T2} state_t;
    typedef enum logic [1:0] {MD_READ, MD_WRITE, MD_FETCH, MD_RSVD} mode_t;

    state_t              state, state_d;
    mode_t               mode_q, mode_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [WCFG_W-1:0]   wcfg_q, wcfg_d;
    logic [WCFG_W-1:0]   wcnt_q, wcnt_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic                abort_q, abort_d;
    logic                cmd_ok;

    assign cmd_ok = START && (mode_t'(MODE) != MD_RSVD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            mode_q  <= MD_READ;
            src_q   <= '0;
            wcfg_q  <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            wcfg_q  <= wcfg_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        src_d   = src_q;
        wcfg_d  = wcfg_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        abort_d = 1'b0;
        case (state)
            S_IDLE, S_T2: begin
                // T2 shares the IDLE command accept so back-to-back cycles skip the idle gap
                state_d = S_IDLE;
                if (cmd_ok) begin
                    state_d = S_T0;
                    mode_d  = mode_t'(MODE);
                    src_d   = SRC;
                    wcfg_d  = WCFG;
                    wcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (wcnt_q < wcfg_q) begin
                    wcnt_d = wcnt_q + WCFG_W'(1);
                end else if (TWAIT) begin
                    if (tcnt_q == TO_MAX) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end else begin
                    state_d = S_T2;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = 1'b0;
        XPT        = 2'b00;
        MREQ       = 1'b0;
        RD         = 1'b0;
        WR         = 1'b0;
        M1         = 1'b0;
        ACT_AD     = 1'b0;
        LATCH_DATA = 1'b0;
        INC_PC     = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        case (state)
            S_IDLE: ERR = abort_q;
            S_T0, S_T1: begin
                BUSY   = 1'b1;
                XPT    = (state == S_T1) ? 2'b01 : 2'b00;
                ACT_AD = 1'b1;
                MREQ   = 1'b1;
                RD     = (mode_q == MD_READ) || (mode_q == MD_FETCH);
                M1     = (mode_q == MD_FETCH);
                WR     = (state == S_T1) && (mode_q == MD_WRITE);
            end
            S_T2: begin
                BUSY       = 1'b1;
                XPT        = 2'b10;
                ACT_AD     = 1'b1;
                LATCH_DATA = (mode_q == MD_READ) || (mode_q == MD_FETCH);
                INC_PC     = (mode_q == MD_FETCH) || ((mode_q == MD_READ) && (src_q == '0));
                DONE       = 1'b1;
            end
            default: ;
        endcase
    end

    // Out-of-range sources match no bit, leaving AD_SEL all zero
    always_comb begin
        AD_SEL = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            AD_SEL[i] = ACT_AD && (src_q == SRC_W'(i));
        end
    end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Self-checking bench for mem_cycle_sequencer: vector table with a scoreboard queue,
// plus hand-written async-reset sequence.
module tb_mem_cycle_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [1:0] SRC = 2'b00;
    logic [1:0] WCFG = 2'b00;
    logic       TWAIT = 1'b0;
    logic       BUSY, MREQ, RD, WR, M1, ACT_AD, LATCH_DATA, INC_PC, DONE, ERR;
    logic [1:0] XPT;
    logic [3:0] AD_SEL;

    mem_cycle_sequencer #(.N_SRC(4), .SRC_W(2), .WCFG_W(2), .WAIT_TIMEOUT(15)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .SRC(SRC), .WCFG(WCFG),
        .TWAIT(TWAIT), .BUSY(BUSY), .XPT(XPT), .MREQ(MREQ), .RD(RD), .WR(WR), .M1(M1),
        .ACT_AD(ACT_AD), .AD_SEL(AD_SEL), .LATCH_DATA(LATCH_DATA), .INC_PC(INC_PC),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // {BUSY, XPT, MREQ, RD, WR, M1, ACT_AD, AD_SEL, LATCH_DATA, INC_PC, DONE, ERR}
    logic [15:0] obs;
    assign obs = {BUSY, XPT, MREQ, RD, WR, M1, ACT_AD, AD_SEL, LATCH_DATA, INC_PC, DONE, ERR};

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic [1:0]  src;
        logic [1:0]  wcfg;
        logic        twait;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0001 << s;
        return r;
    endfunction

    function automatic logic [15:0] e_t0(input logic [1:0] m, input logic [1:0] s);
        return {1'b1, 2'b00, 1'b1, m != 2'd1, 1'b0, m == 2'd2, 1'b1, onehot(s), 4'b0000};
    endfunction

    function automatic logic [15:0] e_t1(input logic [1:0] m, input logic [1:0] s);
        return {1'b1, 2'b01, 1'b1, m != 2'd1, m == 2'd1, m == 2'd2, 1'b1, onehot(s), 4'b0000};
    endfunction

    function automatic logic [15:0] e_t2(input logic [1:0] m, input logic [1:0] s);
        return {1'b1, 2'b10, 4'b0000, 1'b1, onehot(s), m != 2'd1,
                (m == 2'd2) || (m == 2'd0 && s == 2'd0), 1'b1, 1'b0};
    endfunction

    localparam logic [15:0] E_IDLE = 16'h0000;
    localparam logic [15:0] E_ERR  = 16'h0001;

    function automatic void add(input logic st, input logic [1:0] m, input logic [1:0] s,
                                input logic [1:0] w, input logic tw, input logic [15:0] e,
                                input string nm);
        vec_t v;
        v.start = st; v.mode = m; v.src = s; v.wcfg = w; v.twait = tw; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", nm, act, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] e;
        @(negedge CLK);
        START = v.start; MODE = v.mode; SRC = v.src; WCFG = v.wcfg; TWAIT = v.twait;
        sb.push_back(v.exp);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check($sformatf("%s[%0d]", v.name, idx), obs, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // fetch, src0, no waits
        add(1, 2'd2, 2'd0, 2'd0, 0, e_t0(2'd2, 2'd0), "fetch_t0");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t1(2'd2, 2'd0), "fetch_t1");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t2(2'd2, 2'd0), "fetch_t2");
        add(0, 2'd0, 2'd0, 2'd0, 0, E_IDLE, "fetch_idle");
        // write, src2, 2 programmed + 3 external waits; TWAIT high early must not extend T1
        add(1, 2'd1, 2'd2, 2'd2, 0, e_t0(2'd1, 2'd2), "wr_t0");
        for (int i = 0; i < 6; i++) add(0, 2'd0, 2'd0, 2'd0, 1, e_t1(2'd1, 2'd2), "wr_t1");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t2(2'd1, 2'd2), "wr_t2");
        add(0, 2'd0, 2'd0, 2'd0, 1, E_IDLE, "wr_idle");
        // read, src1, TWAIT stuck: 16 cycles of T1 then abort
        add(1, 2'd0, 2'd1, 2'd0, 1, e_t0(2'd0, 2'd1), "to_t0");
        for (int i = 0; i < 16; i++) add(0, 2'd0, 2'd0, 2'd0, 1, e_t1(2'd0, 2'd1), "to_t1");
        add(0, 2'd0, 2'd0, 2'd0, 1, E_ERR, "to_err");
        // restart right after ERR; STARTs in T0/T1 ignored; back-to-back at T2
        add(1, 2'd2, 2'd3, 2'd1, 0, e_t0(2'd2, 2'd3), "b2b_t0");
        add(1, 2'd0, 2'd0, 2'd0, 0, e_t1(2'd2, 2'd3), "b2b_t1");
        add(1, 2'd1, 2'd1, 2'd0, 0, e_t1(2'd2, 2'd3), "b2b_t1w");
        add(1, 2'd0, 2'd0, 2'd0, 0, e_t2(2'd2, 2'd3), "b2b_t2");
        add(1, 2'd0, 2'd0, 2'd0, 0, e_t0(2'd0, 2'd0), "b2b_t0b");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t1(2'd0, 2'd0), "b2b_t1b");
        add(1, 2'd3, 2'd1, 2'd0, 0, e_t2(2'd0, 2'd0), "b2b_t2b");
        add(1, 2'd3, 2'd1, 2'd0, 0, E_IDLE, "rsvd_at_t2");
        add(1, 2'd3, 2'd2, 2'd0, 0, E_IDLE, "rsvd_idle");
        // read src1 with no PC increment, then enter T1 for the async reset test
        add(1, 2'd0, 2'd1, 2'd0, 0, e_t0(2'd0, 2'd1), "rd1_t0");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t1(2'd0, 2'd1), "rd1_t1");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t2(2'd0, 2'd1), "rd1_t2");
        add(1, 2'd0, 2'd1, 2'd2, 0, e_t0(2'd0, 2'd1), "rst_t0");
        add(0, 2'd0, 2'd0, 2'd0, 0, e_t1(2'd0, 2'd1), "rst_t1");

        #1;
        check("reset_state", obs, E_IDLE);
        @(negedge CLK);
        RESET = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // async reset between edges, mid programmed wait
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_now", obs, E_IDLE);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("async_rst_after", obs, E_IDLE);

        begin
            vec_t v;
            v.start = 1; v.mode = 2'd2; v.src = 2'd1; v.wcfg = 2'd0; v.twait = 0;
            v.exp = e_t0(2'd2, 2'd1); v.name = "post_rst_t0";
            run_vec(v, 0);
            v.start = 0; v.exp = e_t1(2'd2, 2'd1); v.name = "post_rst_t1";
            run_vec(v, 0);
            v.exp = e_t2(2'd2, 2'd1); v.name = "post_rst_t2";
            run_vec(v, 0);
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_cycle_sequencer.md
Name: mem_cycle_sequencer

Overview:
- Parametrised memory-access machine-cycle sequencer. It generates its own T-state progression (T0, T1, T1-wait, T2) instead of decoding an externally supplied XPT.
- Supports read, write and opcode-fetch modes, N selectable address sources, programmable plus external wait states, an external-wait timeout, and back-to-back cycles.
- Sits between the instruction-level control decoder and the bus/register-file strobes.

Parameters:
- N_SRC, 4, number of address sources; AD_SEL is one-hot over these.
- SRC_W, 2, width of SRC; must satisfy 2**SRC_W >= N_SRC.
- WCFG_W, 2, width of the programmed wait-state count.
- WAIT_TIMEOUT, 15, maximum consecutive cycles with TWAIT high before abort.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  command strobe; sampled on rising edge.
- MODE  in  2  00 read, 01 write, 10 fetch (M1), 11 reserved.
- SRC  in  SRC_W  address source index; 0 = PC.
- WCFG  in  WCFG_W  programmed wait states inserted in T1.
- TWAIT  in  1  external wait request.
- BUSY  out  1  a cycle is in progress (T0/T1/T2).
- XPT  out  2  current T-state: 00 T0, 01 T1 (including waits), 10 T2; 00 when idle.
- MREQ  out  1  memory request.
- RD  out  1  read strobe.
- WR  out  1  write strobe.
- M1  out  1  opcode-fetch indicator.
- ACT_AD  out  1  drive the address bus.
- AD_SEL  out  N_SRC  one-hot address-source select.
- LATCH_DATA  out  1  capture the data bus into Dtcs.
- INC_PC  out  1  increment PC.
- DONE  out  1  single-cycle completion pulse.
- ERR  out  1  single-cycle timeout pulse.

Behaviour:
- Clocking and reset:
  - One clock; asynchronous, active-high reset.
  - States: IDLE, T0, T1, T2. A registered state, a latched command (mode, src, wcfg), a wait counter (width WCFG_W) and a timeout counter (width clog2(WAIT_TIMEOUT+1)).
  - RESET high: immediately to IDLE, counters cleared, latched command cleared. All outputs are 0, including XPT=00 and AD_SEL=0. This holds mid-cycle too: strobes drop asynchronously.
- Output decoding:
  - All outputs are decoded combinationally from the registered state and latched command only; no input feeds an output directly.
  - Sole exception: DONE/ERR are decoded from state plus the registered abort flag.
- IDLE:
  - All outputs 0.
  - START=1 with MODE != 11 at a clock edge: latch MODE/SRC/WCFG, clear both counters, go to T0.
  - START with MODE=11: ignored, stay IDLE, no ERR.
- T0 (1 cycle):
  - BUSY=1, XPT=00, ACT_AD=1, AD_SEL=onehot(src), MREQ=1.
  - RD=1 for read/fetch; M1=1 for fetch; WR=0.
  - Next state T1.
- T1 (>=1 cycle):
  - Same outputs as T0, except XPT=01 and WR=1 for write.
  - Programmed waits first: while wait counter < wcfg, increment it and stay.
  - Then external waits: while TWAIT=1, increment the timeout counter and stay.
  - TWAIT is sampled only after programmed waits are exhausted. Total T1 length = 1 + wcfg + external-wait cycles.
  - Timeout: if the timeout counter reaches WAIT_TIMEOUT with TWAIT still high, go to IDLE and set the abort flag. ERR=1 for the following cycle.
  - Otherwise next state T2.
- T2 (1 cycle):
  - BUSY=1, XPT=10, ACT_AD=1, AD_SEL held, MREQ=RD=WR=M1=0.
  - LATCH_DATA=1 for read/fetch.
  - INC_PC=1 when mode=fetch, or mode=read with src=0.
  - DONE=1.
- Back-to-back: START=1 (valid MODE) sampled at the T2 edge latches the new command and goes directly to T0. No idle gap.
- START in T0/T1: ignored, no queuing.
- Abort: after ERR, the sequencer is in IDLE and accepts START on the very next edge. No DONE, LATCH_DATA or INC_PC is issued for an aborted cycle.
- Out-of-range src (src >= N_SRC): AD_SEL=0, and the cycle otherwise proceeds normally.
- TWAIT has no effect in T0, T2 or IDLE.

Test Plan:
- Reset then fetch, SRC=0, WCFG=0, TWAIT=0:
  - XPT 00,01,10 over 3 cycles.
  - MREQ=RD=M1=1 for 2 cycles; AD_SEL=0001 for 3 cycles.
  - LATCH_DATA=INC_PC=DONE=1 in cycle 3, then all outputs 0.
- Write, SRC=2, WCFG=2, TWAIT high for 3 cycles after the programmed waits:
  - T1 lasts 6 cycles with WR=1 and RD=0.
  - T2: LATCH_DATA=0, INC_PC=0, DONE=1.
- Read, SRC=1, TWAIT held high:
  - After 1+WAIT_TIMEOUT cycles in T1, return to IDLE.
  - ERR=1 for one cycle; DONE, LATCH_DATA and INC_PC never asserted.
- Back-to-back:
  - Fetch cycle, then START (read, SRC=0) held during T2.
  - Next cycle is T0 (XPT=00, BUSY stays 1).
  - Second T2 asserts INC_PC=1.
- Corner commands:
  - START with MODE=11 in IDLE: stays IDLE, all outputs 0.
  - START during T1: ignored.
- Async reset mid-T1: RESET pulse between clock edges drops MREQ/RD/ACT_AD immediately; BUSY=0 and XPT=00 after release.
